// File: rtl/calib_pkg.sv
// Shared types for the calibration sequencer: FSM state encoding and error-width helpers.
package calib_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_CONVERT = 3'd3,
    ST_EVAL    = 3'd4,
    ST_STEP    = 3'd5,
    ST_DONE    = 3'd6,
    ST_FAIL    = 3'd7
  } calib_state_t;

  localparam int BUS_WIDTH_DEFAULT = 10;
  // One extra bit so the signed difference of two unsigned codes cannot overflow.
  localparam int ERR_W = BUS_WIDTH_DEFAULT + 1;

  function automatic int err_width(input int bus_width);
    return bus_width + 1;
  endfunction

endpackage

// File: rtl/calib_sequencer_if.sv
// Control, solver, DAC and ADC signals of the calibration sequencer grouped as one bundle.
interface calib_sequencer_if #(
  parameter int BUS_WIDTH = 10,
  parameter int ITER_W    = 4
);
  import calib_pkg::*;

  // Handshakes: adc_start is a one-cycle request per conversion; adc_done marks adc_data
  // valid in that same cycle (no backpressure). dac_load and solver_step are one-cycle
  // strobes with no acknowledge; the solver must present its next code by the LOAD cycle.
  logic                 start;
  logic                 abort;
  logic [BUS_WIDTH-1:0] q_desired;
  logic [BUS_WIDTH-1:0] solver_i_ref;
  logic                 went_unstable;
  logic                 solver_step;
  logic [BUS_WIDTH-1:0] dac_code;
  logic                 dac_load;
  logic                 adc_start;
  logic                 adc_done;
  logic [BUS_WIDTH-1:0] adc_data;
  logic [BUS_WIDTH-1:0] q_measured;
  logic [ITER_W-1:0]    iter_count;
  logic                 busy;
  logic                 done;
  logic                 fail;
  calib_state_t         state_dbg;

  modport master (
    input  start, abort, q_desired, solver_i_ref, went_unstable, adc_done, adc_data,
    output solver_step, dac_code, dac_load, adc_start, q_measured, iter_count,
           busy, done, fail, state_dbg
  );

  modport slave (
    output start, abort, q_desired, solver_i_ref, went_unstable, adc_done, adc_data,
    input  solver_step, dac_code, dac_load, adc_start, q_measured, iter_count,
           busy, done, fail, state_dbg
  );

endinterface

// File: rtl/settle_timer.sv
// Loadable down-counter; expire flags the last enabled cycle of a loaded interval.
module settle_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] value,
  output logic         expire
);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (en && count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign expire = en && (count == W'(1));

endmodule

// File: rtl/calib_sequencer.sv
// Calibration loop sequencer: DAC load, settle, ADC convert, evaluate, step the solver.
// Define CALIB_SEQ_BEST_EN to restore the lowest-error code and sample when entering FAIL.
module calib_sequencer
  import calib_pkg::*;
#(
  parameter int BUS_WIDTH      = 10,
  parameter int TOL            = 30,
  parameter int SETTLE_CYCLES  = 16,
  parameter int MAX_ITER       = 12,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic              clk,
  input logic              rst,
  calib_sequencer_if.master bus
);

  localparam int ITER_W = $clog2(MAX_ITER + 1);
  localparam int EW     = err_width(BUS_WIDTH);
  localparam int SW     = $clog2(SETTLE_CYCLES + 1);
  localparam int TW     = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [2:0] S_IDLE    = ST_IDLE;
  localparam logic [2:0] S_LOAD    = ST_LOAD;
  localparam logic [2:0] S_SETTLE  = ST_SETTLE;
  localparam logic [2:0] S_CONVERT = ST_CONVERT;
  localparam logic [2:0] S_EVAL    = ST_EVAL;
  localparam logic [2:0] S_STEP    = ST_STEP;
  localparam logic [2:0] S_DONE    = ST_DONE;
  localparam logic [2:0] S_FAIL    = ST_FAIL;

  logic [2:0]           state, next;
  logic [BUS_WIDTH-1:0] dac_code_reg, q_meas_reg;
  logic [ITER_W-1:0]    iter_reg;
  logic                 dac_load_reg, adc_start_reg, step_reg;
  logic                 busy_reg, done_reg, fail_reg;
  logic                 settle_exp, tmo_exp;
  logic signed [EW-1:0] diff;
  logic [EW-1:0]        err;

  assign diff = $signed({1'b0, q_meas_reg}) - $signed({1'b0, bus.q_desired});
  assign err  = diff[EW-1] ? $unsigned(-diff) : $unsigned(diff);

  settle_timer #(.W(SW)) u_settle (
    .clk(clk), .rst(rst),
    .load(state == S_LOAD), .en(state == S_SETTLE),
    .value(SW'(SETTLE_CYCLES)), .expire(settle_exp)
  );

  settle_timer #(.W(TW)) u_timeout (
    .clk(clk), .rst(rst),
    .load(state == S_SETTLE && settle_exp), .en(state == S_CONVERT),
    .value(TW'(TIMEOUT_CYCLES)), .expire(tmo_exp)
  );

  always_comb begin
    next = state;
    case (state)
      S_IDLE, S_DONE, S_FAIL: if (bus.start) next = S_LOAD;
      S_LOAD:                 next = S_SETTLE;
      S_SETTLE:               if (settle_exp) next = S_CONVERT;
      S_CONVERT: begin
        if (bus.adc_done)  next = S_EVAL;
        else if (tmo_exp)  next = S_FAIL;
      end
      S_EVAL: begin
        if (err < EW'(TOL))                        next = S_DONE;
        else if (bus.went_unstable)                next = S_FAIL;
        else if (iter_reg == ITER_W'(MAX_ITER))    next = S_FAIL;
        else                                       next = S_STEP;
      end
      S_STEP:                 next = S_LOAD;
      default:                next = S_IDLE;
    endcase
    if (bus.abort) next = S_IDLE;
  end

`ifdef CALIB_SEQ_BEST_EN
  logic                 best_valid;
  logic [EW-1:0]        best_err;
  logic [BUS_WIDTH-1:0] best_code, best_q;
  logic                 take_cur;

  // The sample being evaluated right now may itself be the best one.
  assign take_cur = (state == S_EVAL) && (!best_valid || err < best_err);
`endif

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      dac_code_reg  <= '0;
      q_meas_reg    <= '0;
      iter_reg      <= '0;
      dac_load_reg  <= 1'b0;
      adc_start_reg <= 1'b0;
      step_reg      <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      fail_reg      <= 1'b0;
`ifdef CALIB_SEQ_BEST_EN
      best_valid    <= 1'b0;
      best_err      <= '1;
      best_code     <= '0;
      best_q        <= '0;
`endif
    end else begin
      state         <= next;
      dac_load_reg  <= (next == S_LOAD);
      adc_start_reg <= (next == S_CONVERT) && (state != S_CONVERT);
      step_reg      <= (next == S_STEP);
      busy_reg      <= (next == S_LOAD) || (next == S_SETTLE) || (next == S_CONVERT) ||
                       (next == S_EVAL) || (next == S_STEP);
      done_reg      <= (next == S_DONE);
      fail_reg      <= (next == S_FAIL);
      if (state == S_LOAD && next == S_SETTLE) dac_code_reg <= bus.solver_i_ref;
      if (state == S_CONVERT && next == S_EVAL) q_meas_reg <= bus.adc_data;
      if (next == S_LOAD && state != S_STEP) iter_reg <= '0;
      else if (next == S_STEP)              iter_reg <= iter_reg + 1'b1;
`ifdef CALIB_SEQ_BEST_EN
      if (next == S_LOAD && state != S_STEP) begin
        best_valid <= 1'b0;
        best_err   <= '1;
      end else if (next != S_IDLE && take_cur) begin
        best_valid <= 1'b1;
        best_err   <= err;
        best_code  <= dac_code_reg;
        best_q     <= q_meas_reg;
      end
      if (next == S_FAIL && state != S_FAIL && (best_valid || take_cur)) begin
        dac_load_reg <= 1'b1;
        if (!take_cur) begin
          dac_code_reg <= best_code;
          q_meas_reg   <= best_q;
        end
      end
`endif
    end
  end

  assign bus.dac_code    = dac_code_reg;
  assign bus.dac_load    = dac_load_reg;
  assign bus.adc_start   = adc_start_reg;
  assign bus.solver_step = step_reg;
  assign bus.q_measured  = q_meas_reg;
  assign bus.iter_count  = iter_reg;
  assign bus.busy        = busy_reg;
  assign bus.done        = done_reg;
  assign bus.fail        = fail_reg;
  assign bus.state_dbg   = calib_state_t'(state);

endmodule

// File: tb/tb_calib_sequencer.sv
// Bench for calib_sequencer: directed cases plus randomized runs scored against a loop model.
module tb_calib_sequencer;
  import calib_pkg::*;

  localparam int BW  = 10;
  localparam int TOL = 30;
  localparam int SET = 5;
  localparam int MI  = 3;
  localparam int TMO = 40;
  localparam int IW  = $clog2(MI + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  calib_sequencer_if #(.BUS_WIDTH(BW), .ITER_W(IW)) bus ();

  calib_sequencer #(
    .BUS_WIDTH(BW), .TOL(TOL), .SETTLE_CYCLES(SET), .MAX_ITER(MI), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  // Scenario description: per-iteration ADC sample, ADC latency (-1 = never), unstable flag, code.
  int qd;
  int samp[4];
  int dly[4];
  int unst[4];
  int code[4];
  int scen = 0;
  int exp_outcome;
  int model_code = 0;
  int model_q    = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_next(input string tag, input int got);
    int e;
    e = -1;
    if (exp_q.size() > 0) e = int'(exp_q.pop_front());
    check($sformatf("s%0d_%s", scen, tag), got, e);
  endtask

  // Reference: walk the iteration rules with plain integers and predict the end of the run.
  task automatic model_run();
    int t, steps, loads, starts, best_err, best_i, term, outc, err;
    t = 0; steps = 0; loads = 0; starts = 0; best_err = 1 << 30; best_i = -1;
    term = 0; outc = 0;
    for (int i = 0; i <= MI; i++) begin
      loads++;
      starts++;
      model_code = code[i];
      if (dly[i] < 0) begin
        outc = 2;
        term = t + 2 + SET + TMO;
        break;
      end
      err = samp[i] - qd;
      if (err < 0) err = -err;
      model_q = samp[i];
      if (err < best_err) begin
        best_err = err;
        best_i   = i;
      end
      if (err < TOL) begin
        outc = 1;
        term = t + 4 + SET + dly[i];
        break;
      end
      if (unst[i] != 0 || steps == MI) begin
        outc = 2;
        term = t + 4 + SET + dly[i];
        break;
      end
      steps++;
      t = t + 4 + SET + dly[i];
    end
`ifdef CALIB_SEQ_BEST_EN
    if (outc == 2 && best_i >= 0) begin
      model_code = code[best_i];
      model_q    = samp[best_i];
      loads++;
    end
`endif
    exp_outcome = outc;
    exp_q.push_back(32'(outc));
    exp_q.push_back(32'(term));
    exp_q.push_back(32'(steps));
    exp_q.push_back(32'(model_code));
    exp_q.push_back(32'(model_q));
    exp_q.push_back(32'(loads));
    exp_q.push_back(32'(steps));
    exp_q.push_back(32'(starts));
  endtask

  task automatic run_scenario();
    int cyc, idx, rem, n_load, n_step, n_start, busy_gap;
    bit fin;
    scen++;
    model_run();
    bus.q_desired     = BW'(qd);
    idx               = 0;
    bus.solver_i_ref  = BW'(code[0]);
    bus.went_unstable = (unst[0] != 0);
    bus.start         = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    cyc = 1; rem = -1; n_load = 0; n_step = 0; n_start = 0; busy_gap = 0; fin = 1'b0;
    while (!fin && cyc <= 1000) begin
      if (bus.dac_load)  n_load++;
      if (bus.adc_start) n_start++;
      if (bus.solver_step) begin
        n_step++;
        if (idx < MI) idx++;
        bus.solver_i_ref  = BW'(code[idx]);
        bus.went_unstable = (unst[idx] != 0);
      end
      if (bus.done || bus.fail) begin
        fin = 1'b1;
        bus.adc_done = 1'b0;
        bus.start    = 1'b0;
      end else begin
        if (!bus.busy) busy_gap++;
        bus.adc_done = 1'b0;
        bus.adc_data = BW'($urandom);
        if (bus.adc_start) rem = dly[idx];
        if (rem == 0) begin
          bus.adc_done = 1'b1;
          bus.adc_data = BW'(samp[idx]);
          rem = -1;
        end else if (rem > 0) begin
          rem--;
        end
        bus.start = ($urandom_range(0, 7) == 0);
        @(posedge clk); #1;
        cyc++;
      end
    end
    if (!fin) begin
      check($sformatf("s%0d_terminate", scen), 0, 1);
      bus.abort = 1'b1;
      @(posedge clk); #1;
      bus.abort = 1'b0;
    end
    check_next("outcome", int'(bus.done) + 2 * int'(bus.fail));
    check_next("cycles", cyc);
    check_next("iter_count", int'(bus.iter_count));
    check_next("dac_code", int'(bus.dac_code));
    check_next("q_measured", int'(bus.q_measured));
    check_next("dac_loads", n_load);
    check_next("solver_steps", n_step);
    check_next("adc_starts", n_start);
    check($sformatf("s%0d_busy_gaps", scen), busy_gap, 0);
    check($sformatf("s%0d_busy_end", scen), int'(bus.busy), 0);
    @(posedge clk); #1;
    check($sformatf("s%0d_hold", scen), int'(bus.done) + 2 * int'(bus.fail), exp_outcome);
    check($sformatf("s%0d_load_once", scen), int'(bus.dac_load), 0);
    if ($urandom_range(0, 1) == 1) begin
      bus.abort = 1'b1;
      @(posedge clk); #1;
      bus.abort = 1'b0;
      check($sformatf("s%0d_abort_clear", scen),
            int'(bus.done) + 2 * int'(bus.fail) + 4 * int'(bus.busy), 0);
    end
  endtask

  task automatic set_iter(input int i, input int s, input int d, input int u, input int c);
    samp[i] = s; dly[i] = d; unst[i] = u; code[i] = c;
  endtask

  task automatic abort_test();
    int n_start, n_busy;
    bus.q_desired    = BW'(500);
    bus.solver_i_ref = BW'(777);
    bus.start        = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    check("abort_pre_busy", int'(bus.busy), 1);
    bus.abort = 1'b1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.abort        = 1'b0;
    bus.start        = 1'b0;
    bus.solver_i_ref = BW'(12);
    check("abort_busy", int'(bus.busy), 0);
    check("abort_flags", int'(bus.done) + 2 * int'(bus.fail), 0);
    check("abort_dac_code", int'(bus.dac_code), 777);
    check("abort_state", int'(bus.state_dbg), int'(ST_IDLE));
    n_start = 0; n_busy = 0;
    repeat (SET + 6) begin
      @(posedge clk); #1;
      if (bus.adc_start) n_start++;
      if (bus.busy || bus.dac_load) n_busy++;
    end
    check("abort_no_adc_start", n_start, 0);
    check("abort_stays_idle", n_busy, 0);
    model_code = 777;
  endtask

  initial begin
    bus.start = 1'b0; bus.abort = 1'b0; bus.q_desired = '0; bus.solver_i_ref = '0;
    bus.went_unstable = 1'b0; bus.adc_done = 1'b0; bus.adc_data = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_dac_code", int'(bus.dac_code), 0);
    check("rst_q_measured", int'(bus.q_measured), 0);
    check("rst_iter_count", int'(bus.iter_count), 0);
    check("rst_status", int'(bus.busy) + 2 * int'(bus.done) + 4 * int'(bus.fail), 0);
    check("rst_pulses", int'(bus.dac_load) + 2 * int'(bus.adc_start) + 4 * int'(bus.solver_step), 0);
    check("rst_state", int'(bus.state_dbg), int'(ST_IDLE));
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_after_rst", int'(bus.busy), 0);

    // Converge on the first pass.
    qd = 500;
    set_iter(0, 510, 2, 0, 321); set_iter(1, 0, 0, 0, 0);
    set_iter(2, 0, 0, 0, 0);     set_iter(3, 0, 0, 0, 0);
    run_scenario();
    // Two solver steps before convergence.
    set_iter(0, 700, 1, 0, 100); set_iter(1, 600, 0, 0, 200);
    set_iter(2, 515, 3, 0, 300); set_iter(3, 0, 0, 0, 400);
    run_scenario();
    // Iteration limit reached with a constant far-off sample.
    set_iter(0, 0, 2, 0, 11); set_iter(1, 0, 1, 0, 22);
    set_iter(2, 0, 0, 0, 33); set_iter(3, 0, 4, 0, 44);
    run_scenario();
    // ADC never answers.
    set_iter(0, 0, -1, 0, 55);
    run_scenario();
    // Timeout after one evaluated iteration.
    set_iter(0, 800, 0, 0, 66); set_iter(1, 0, -1, 0, 77);
    run_scenario();
    // Unstable with large error fails; unstable with small error still converges.
    set_iter(0, 600, 1, 1, 88);
    run_scenario();
    set_iter(0, 471, 1, 1, 99);
    run_scenario();
    // Exactly at the tolerance boundary: 530 is not converged, 529 is.
    set_iter(0, 530, 0, 0, 901); set_iter(1, 529, 0, 0, 902);
    run_scenario();

    abort_test();

    for (int r = 0; r < 40; r++) begin
      qd = int'($urandom_range(0, 1023));
      for (int i = 0; i <= MI; i++) begin
        code[i] = int'($urandom_range(0, 1023));
        dly[i]  = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 6));
        unst[i] = ($urandom_range(0, 5) == 0) ? 1 : 0;
        if ($urandom_range(0, 2) == 0) begin
          samp[i] = qd + int'($urandom_range(0, 2 * TOL - 2)) - (TOL - 1);
          if (samp[i] < 0)    samp[i] = 0;
          if (samp[i] > 1023) samp[i] = 1023;
        end else begin
          samp[i] = int'($urandom_range(0, 1023));
        end
      end
      run_scenario();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
